// File: rtl/div_fl_ctrl.sv
// Turns TRcal/DR into divider M/N and sequences div_en for one tag reply, counting doub_flc edges.
// Config result 3 cycles after cfg_req; reply_done follows a fixed drain after div_en falls.
module div_fl_ctrl #(
    parameter int         TRCAL_W   = 12,
    parameter int         P_MIN     = 4,
    parameter logic [9:0] M_RST     = 10'd100,
    parameter logic       N_RST     = 1'b0,
    parameter int         DRAIN_CYC = 1024
) (
    input  logic               base_clk,
    input  logic               rst,
    input  logic               cfg_req,
    input  logic [TRCAL_W-1:0] trcal_cnt,
    input  logic               dr,
    input  logic               reply_req,
    input  logic [15:0]        reply_len,
    input  logic               abort,
    input  logic               doub_flc,
    output logic [9:0]         M,
    output logic               N,
    output logic               div_en,
    output logic               cfg_valid,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic               busy,
    output logic               reply_done,
    output logic               reply_abt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_CHECK,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam int P_W    = 15;
    localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

    state_t              state;
    state_t              state_nxt;

    logic [TRCAL_W-1:0]  trcal_q;
    logic                dr_q;
    logic [P_W-1:0]      trcal_x;
    logic [P_W-1:0]      p_calc;
    logic [P_W-1:0]      p_q;
    logic                cfg_bad;

    logic [15:0]         reply_len_q;
    logic [15:0]         edge_cnt;
    logic [15:0]         edge_inc;
    logic [DCNT_W-1:0]   drain_cnt;
    logic                abort_flag;

    logic                sync1;
    logic                sync2;
    logic                sync3;
    logic                flc_rise;
    logic                last_edge;

    logic                cfg_take;
    logic                reply_take;
    logic                reply_zero;
    logic                drain_end;

    // Round-to-nearest divider period; 3*trcal built from a shift and add.
    assign trcal_x = P_W'(trcal_q);
    assign p_calc  = dr_q ? (((trcal_x << 1) + trcal_x + P_W'(32)) >> 6)
                          : ((trcal_x + P_W'(4)) >> 3);
    assign cfg_bad = (trcal_q == '0) || (p_q < P_W'(P_MIN));

    assign flc_rise  = sync2 & ~sync3;
    assign edge_inc  = edge_cnt + 16'd1;
    assign last_edge = flc_rise && (edge_inc == reply_len_q);

    assign busy = (state != S_IDLE);

    always_ff @(posedge base_clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cfg_take   = 1'b0;
        reply_take = 1'b0;
        reply_zero = 1'b0;
        drain_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_req) begin
                    cfg_take  = 1'b1;
                    state_nxt = S_CALC;
                end else if (reply_req && cfg_valid) begin
                    reply_take = 1'b1;
                    if (reply_len == 16'd0) begin
                        reply_zero = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_CALC:  state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_IDLE;
            S_RUN: begin
                // Abort and the final edge share the same exit; the abort flag decides reply_abt.
                if (abort || last_edge) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DCNT_W'(DRAIN_CYC)) begin
                    drain_end = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge base_clk or posedge rst) begin
        if (rst) begin
            trcal_q   <= '0;
            dr_q      <= 1'b0;
            p_q       <= '0;
            M         <= M_RST;
            N         <= N_RST;
            cfg_valid <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            if (cfg_take) begin
                trcal_q <= trcal_cnt;
                dr_q    <= dr;
            end
            if (state == S_CALC) begin
                p_q <= p_calc;
            end
            // CHECK is the only place M/N move, so they stay frozen through RUN and DRAIN.
            if (state == S_CHECK) begin
                cfg_done <= 1'b1;
                if (cfg_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    M         <= 10'(p_q >> 1);
                    N         <= p_q[0];
                    cfg_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge base_clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            reply_len_q <= '0;
            edge_cnt    <= '0;
            drain_cnt   <= '0;
            abort_flag  <= 1'b0;
            div_en      <= 1'b0;
            reply_done  <= 1'b0;
            reply_abt   <= 1'b0;
        end else begin
            sync1      <= doub_flc;
            sync2      <= sync1;
            sync3      <= sync2;
            reply_done <= 1'b0;
            reply_abt  <= 1'b0;
            div_en     <= (state_nxt == S_RUN);
            if (reply_take) begin
                reply_len_q <= reply_len;
                edge_cnt    <= '0;
            end
            if (reply_zero) begin
                reply_done <= 1'b1;
            end
            if (state == S_RUN) begin
                if (flc_rise) begin
                    edge_cnt <= edge_inc;
                end
                if (abort) begin
                    abort_flag <= 1'b1;
                end
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DCNT_W'(1);
            end else begin
                drain_cnt <= '0;
            end
            if (drain_end) begin
                reply_done <= 1'b1;
                reply_abt  <= abort_flag;
                abort_flag <= 1'b0;
                edge_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_fl_ctrl.sv
// Bench for div_fl_ctrl: arithmetic config model plus a behavioural divider driving doub_flc.
module tb_div_fl_ctrl;

    localparam int DRAIN_CYC = 1024;

    logic        base_clk  = 1'b0;
    logic        rst       = 1'b1;
    logic        cfg_req   = 1'b0;
    logic [11:0] trcal_cnt = '0;
    logic        dr        = 1'b0;
    logic        reply_req = 1'b0;
    logic [15:0] reply_len = '0;
    logic        abort     = 1'b0;
    logic        doub_flc  = 1'b0;
    logic [9:0]  M;
    logic        N;
    logic        div_en;
    logic        cfg_valid;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;
    logic        reply_done;
    logic        reply_abt;

    int vectors     = 0;
    int miscompares = 0;

    int cyc           = 0;
    int rise_cnt      = 0;
    int last_rise_cyc = 0;
    int ph            = 0;

    int exp_m = 100;
    int exp_n = 0;
    bit exp_valid = 1'b0;

    div_fl_ctrl #(
        .TRCAL_W  (12),
        .P_MIN    (4),
        .M_RST    (10'd100),
        .N_RST    (1'b0),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .base_clk  (base_clk),
        .rst       (rst),
        .cfg_req   (cfg_req),
        .trcal_cnt (trcal_cnt),
        .dr        (dr),
        .reply_req (reply_req),
        .reply_len (reply_len),
        .abort     (abort),
        .doub_flc  (doub_flc),
        .M         (M),
        .N         (N),
        .div_en    (div_en),
        .cfg_valid (cfg_valid),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .reply_done(reply_done),
        .reply_abt (reply_abt)
    );

    always #5 base_clk = ~base_clk;

    // Divider: period 2M+N while enabled, high for the first half, idle low otherwise.
    always @(posedge base_clk) begin : divider_model
        int pp;
        cyc = cyc + 1;
        #1;
        if (div_en) begin
            pp = 2 * int'(M) + int'(N);
            if (pp < 2) pp = 2;
            if (ph == 0) begin
                rise_cnt      = rise_cnt + 1;
                last_rise_cyc = cyc;
            end
            doub_flc = (ph < pp / 2);
            ph = (ph + 1 >= pp) ? 0 : ph + 1;
        end else begin
            ph       = 0;
            doub_flc = 1'b0;
        end
    end

    function automatic int ref_p(input int t, input bit d);
        return d ? (3 * t + 32) / 64 : (t + 4) / 8;
    endfunction

    task automatic do_cfg(input int t, input bit d, output int lat, output bit err, output bit pulse_ok);
        @(negedge base_clk);
        cfg_req   = 1'b1;
        trcal_cnt = 12'(t);
        dr        = d;
        lat = 0;
        do begin
            @(negedge base_clk);
            cfg_req = 1'b0;
            lat++;
        end while (!cfg_done && lat < 10);
        err = cfg_err;
        @(negedge base_clk);
        pulse_ok = !cfg_done && !cfg_err;
    endtask

    task automatic run_reply(input int len, input int abort_rise, input bit abort_last,
                             output int n_rises, output int fall_gap, output int abort_gap,
                             output int drain_gap, output bit abt, output bit pulse_ok);
        int base, fall_cyc, abort_cyc, done_cyc;
        bit aborted;
        fall_cyc = -1; abort_cyc = -1000; done_cyc = -1; aborted = 1'b0; abt = 1'b0;
        @(negedge base_clk);
        base      = rise_cnt;
        reply_req = 1'b1;
        reply_len = 16'(len);
        @(negedge base_clk);
        reply_req = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if (!div_en) begin
                fall_cyc = cyc;
                break;
            end
            if (!aborted && abort_rise > 0 && rise_cnt - base >= abort_rise) begin
                aborted = 1'b1; abort = 1'b1; abort_cyc = cyc;
            end else if (!aborted && abort_last && rise_cnt - base >= len && cyc == last_rise_cyc + 2) begin
                aborted = 1'b1; abort = 1'b1; abort_cyc = cyc;
            end
            @(negedge base_clk);
            abort = 1'b0;
        end
        n_rises   = rise_cnt - base;
        fall_gap  = fall_cyc - last_rise_cyc;
        abort_gap = fall_cyc - abort_cyc;
        for (int t = 0; t < DRAIN_CYC + 50; t++) begin
            if (reply_done) begin
                done_cyc = cyc;
                abt      = reply_abt;
                break;
            end
            @(negedge base_clk);
        end
        drain_gap = done_cyc - fall_cyc;
        @(negedge base_clk);
        pulse_ok = (done_cyc >= 0) && !reply_done && !div_en;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge base_clk);
        vectors++; if (div_en !== 1'b0) begin miscompares++; $display("FAIL rst_div_en: got %b want 0", div_en); end
        vectors++; if (cfg_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_valid: got %b want 0", cfg_valid); end
        rst = 1'b0;
        @(negedge base_clk);
        vectors++; if (M !== 10'd100) begin miscompares++; $display("FAIL rst_M: got %0d want 100", M); end
        vectors++; if (N !== 1'b0) begin miscompares++; $display("FAIL rst_N: got %b want 0", N); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if ({cfg_done, cfg_err, reply_done, reply_abt} !== 4'b0) begin
            miscompares++; $display("FAIL rst_pulses: got %b want 0000", {cfg_done, cfg_err, reply_done, reply_abt});
        end
    endtask

    task automatic test_reply_no_cfg();
        bit saw_en, saw_done, saw_busy;
        saw_en = 1'b0; saw_done = 1'b0; saw_busy = 1'b0;
        @(negedge base_clk);
        reply_req = 1'b1;
        reply_len = 16'd8;
        for (int t = 0; t < 20; t++) begin
            @(negedge base_clk);
            reply_req = 1'b0;
            if (div_en) saw_en = 1'b1;
            if (reply_done) saw_done = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        vectors++; if (saw_en !== 1'b0) begin miscompares++; $display("FAIL nocfg_div_en: got %b want 0", saw_en); end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL nocfg_done: got %b want 0", saw_done); end
        vectors++; if (saw_busy !== 1'b0) begin miscompares++; $display("FAIL nocfg_busy: got %b want 0", saw_busy); end
    endtask

    task automatic test_cfg_basic();
        int tr[3]   = '{1600, 1600, 1601};
        bit dv[3]   = '{1'b0, 1'b1, 1'b1};
        int em[3]   = '{100, 37, 37};
        int en[3]   = '{0, 1, 1};
        int lat;
        bit err, pulse_ok;
        for (int i = 0; i < 3; i++) begin
            do_cfg(tr[i], dv[i], lat, err, pulse_ok);
            exp_m = em[i]; exp_n = en[i]; exp_valid = 1'b1;
            vectors++; if (lat !== 3) begin miscompares++; $display("FAIL cfg_lat[%0d]: got %0d want 3", i, lat); end
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL cfg_err[%0d]: got %b want 0", i, err); end
            vectors++; if (M !== 10'(em[i])) begin miscompares++; $display("FAIL cfg_M[%0d]: got %0d want %0d", i, M, em[i]); end
            vectors++; if (N !== 1'(en[i])) begin miscompares++; $display("FAIL cfg_N[%0d]: got %b want %0d", i, N, en[i]); end
            vectors++; if (cfg_valid !== 1'b1) begin miscompares++; $display("FAIL cfg_valid[%0d]: got %b want 1", i, cfg_valid); end
            vectors++; if (pulse_ok !== 1'b1) begin miscompares++; $display("FAIL cfg_pulse[%0d]: got %b want 1", i, pulse_ok); end
        end
    endtask

    task automatic test_cfg_err();
        int tr[2] = '{20, 0};
        bit dv[2] = '{1'b0, 1'b1};
        int lat;
        bit err, pulse_ok;
        for (int i = 0; i < 2; i++) begin
            do_cfg(tr[i], dv[i], lat, err, pulse_ok);
            vectors++; if (lat !== 3) begin miscompares++; $display("FAIL cfgerr_lat[%0d]: got %0d want 3", i, lat); end
            vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL cfgerr_err[%0d]: got %b want 1", i, err); end
            vectors++; if (M !== 10'(exp_m) || N !== 1'(exp_n)) begin
                miscompares++; $display("FAIL cfgerr_MN[%0d]: got %0d/%b want %0d/%0d", i, M, N, exp_m, exp_n);
            end
            vectors++; if (cfg_valid !== exp_valid) begin miscompares++; $display("FAIL cfgerr_valid[%0d]: got %b want %b", i, cfg_valid, exp_valid); end
        end
    endtask

    task automatic test_cfg_random();
        int t, p, lat;
        bit d, e_err, err, pulse_ok;
        for (int i = 0; i < 24; i++) begin
            t = (i % 3 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 4095));
            d = 1'($urandom_range(0, 1));
            p = ref_p(t, d);
            e_err = (t == 0) || (p < 4);
            if (!e_err) begin
                exp_m = p / 2; exp_n = p % 2; exp_valid = 1'b1;
            end
            do_cfg(t, d, lat, err, pulse_ok);
            vectors++; if (err !== e_err) begin miscompares++; $display("FAIL rnd_err t=%0d dr=%b: got %b want %b", t, d, err, e_err); end
            vectors++; if (M !== 10'(exp_m) || N !== 1'(exp_n)) begin
                miscompares++; $display("FAIL rnd_MN t=%0d dr=%b: got %0d/%b want %0d/%0d", t, d, M, N, exp_m, exp_n);
            end
            vectors++; if (cfg_valid !== exp_valid || lat !== 3) begin
                miscompares++; $display("FAIL rnd_valid_lat t=%0d: got %b/%0d want %b/3", t, cfg_valid, lat, exp_valid);
            end
        end
    endtask

    task automatic set_cfg_m4();
        int lat;
        bit err, pulse_ok;
        do_cfg(64, 1'b0, lat, err, pulse_ok);
        exp_m = 4; exp_n = 0; exp_valid = 1'b1;
        vectors++; if (M !== 10'd4 || N !== 1'b0 || err !== 1'b0) begin
            miscompares++; $display("FAIL cfg64_MN: got %0d/%b err %b want 4/0 err 0", M, N, err);
        end
    endtask

    task automatic test_reply_normal();
        int nr, fg, ag, dg;
        bit abt, pulse_ok;
        set_cfg_m4();
        run_reply(16, 0, 1'b0, nr, fg, ag, dg, abt, pulse_ok);
        vectors++; if (nr !== 16) begin miscompares++; $display("FAIL norm_rises: got %0d want 16", nr); end
        vectors++; if (fg !== 3) begin miscompares++; $display("FAIL norm_fall_gap: got %0d want 3", fg); end
        vectors++; if (dg !== DRAIN_CYC + 1) begin miscompares++; $display("FAIL norm_drain: got %0d want %0d", dg, DRAIN_CYC + 1); end
        vectors++; if (abt !== 1'b0) begin miscompares++; $display("FAIL norm_abt: got %b want 0", abt); end
        vectors++; if (pulse_ok !== 1'b1) begin miscompares++; $display("FAIL norm_pulse: got %b want 1", pulse_ok); end
    endtask

    task automatic test_reply_abort();
        int nr, fg, ag, dg;
        bit abt, pulse_ok;
        run_reply(16, 5, 1'b0, nr, fg, ag, dg, abt, pulse_ok);
        vectors++; if (ag !== 1) begin miscompares++; $display("FAIL abt_en_gap: got %0d want 1", ag); end
        vectors++; if (nr !== 5) begin miscompares++; $display("FAIL abt_rises: got %0d want 5", nr); end
        vectors++; if (dg !== DRAIN_CYC + 1) begin miscompares++; $display("FAIL abt_drain: got %0d want %0d", dg, DRAIN_CYC + 1); end
        vectors++; if (abt !== 1'b1) begin miscompares++; $display("FAIL abt_flag: got %b want 1", abt); end
        vectors++; if (pulse_ok !== 1'b1) begin miscompares++; $display("FAIL abt_pulse: got %b want 1", pulse_ok); end
    endtask

    task automatic test_abort_last_edge();
        int nr, fg, ag, dg;
        bit abt, pulse_ok;
        run_reply(16, 0, 1'b1, nr, fg, ag, dg, abt, pulse_ok);
        vectors++; if (nr !== 16 || fg !== 3) begin miscompares++; $display("FAIL last_rises_gap: got %0d/%0d want 16/3", nr, fg); end
        vectors++; if (ag !== 1) begin miscompares++; $display("FAIL last_abort_gap: got %0d want 1", ag); end
        vectors++; if (abt !== 1'b1) begin miscompares++; $display("FAIL last_abt: got %b want 1", abt); end
    endtask

    task automatic test_cfg_during_run();
        bit saw_cfg_done, mn_changed, got_done, en_at_cfg;
        saw_cfg_done = 1'b0; mn_changed = 1'b0; got_done = 1'b0;
        @(negedge base_clk);
        reply_req = 1'b1;
        reply_len = 16'd16;
        @(negedge base_clk);
        reply_req = 1'b0;
        repeat (10) @(negedge base_clk);
        en_at_cfg = div_en;
        cfg_req = 1'b1; trcal_cnt = 12'd1600; dr = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge base_clk);
            cfg_req = 1'b0;
            if (cfg_done) saw_cfg_done = 1'b1;
            if (M !== 10'd4 || N !== 1'b0) mn_changed = 1'b1;
            if (reply_done) begin got_done = 1'b1; break; end
        end
        repeat (6) begin
            @(negedge base_clk);
            if (cfg_done) saw_cfg_done = 1'b1;
            if (M !== 10'd4 || N !== 1'b0) mn_changed = 1'b1;
        end
        vectors++; if (en_at_cfg !== 1'b1) begin miscompares++; $display("FAIL run_cfg_en: got %b want 1", en_at_cfg); end
        vectors++; if (saw_cfg_done !== 1'b0) begin miscompares++; $display("FAIL run_cfg_done: got %b want 0", saw_cfg_done); end
        vectors++; if (mn_changed !== 1'b0) begin miscompares++; $display("FAIL run_cfg_MN: got M=%0d N=%b want 4/0", M, N); end
        vectors++; if (got_done !== 1'b1) begin miscompares++; $display("FAIL run_cfg_reply_done: got %b want 1", got_done); end
    endtask

    task automatic test_rst_mid_run();
        bit en_before, saw_done, saw_en;
        saw_done = 1'b0; saw_en = 1'b0;
        @(negedge base_clk);
        reply_req = 1'b1;
        reply_len = 16'd16;
        @(negedge base_clk);
        reply_req = 1'b0;
        repeat (20) @(negedge base_clk);
        en_before = div_en;
        rst = 1'b1;
        #1;
        vectors++; if (en_before !== 1'b1) begin miscompares++; $display("FAIL rstrun_en_before: got %b want 1", en_before); end
        vectors++; if (div_en !== 1'b0) begin miscompares++; $display("FAIL rstrun_div_en: got %b want 0", div_en); end
        vectors++; if (cfg_valid !== 1'b0) begin miscompares++; $display("FAIL rstrun_cfg_valid: got %b want 0", cfg_valid); end
        exp_m = 100; exp_n = 0; exp_valid = 1'b0;
        @(negedge base_clk);
        rst = 1'b0;
        for (int t = 0; t < DRAIN_CYC + 100; t++) begin
            @(negedge base_clk);
            if (reply_done) saw_done = 1'b1;
            if (div_en) saw_en = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0 || saw_en !== 1'b0) begin
            miscompares++; $display("FAIL rstrun_after: got done=%b en=%b want 0/0", saw_done, saw_en);
        end
        vectors++; if (M !== 10'd100 || N !== 1'b0) begin miscompares++; $display("FAIL rstrun_MN: got %0d/%b want 100/0", M, N); end
    endtask

    task automatic test_reply_len0();
        bit saw_en;
        saw_en = 1'b0;
        set_cfg_m4();
        @(negedge base_clk);
        reply_req = 1'b1;
        reply_len = 16'd0;
        @(negedge base_clk);
        reply_req = 1'b0;
        vectors++; if (reply_done !== 1'b1 || reply_abt !== 1'b0) begin
            miscompares++; $display("FAIL len0_done: got %b abt %b want 1 abt 0", reply_done, reply_abt);
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL len0_busy: got %b want 0", busy); end
        if (div_en) saw_en = 1'b1;
        @(negedge base_clk);
        vectors++; if (reply_done !== 1'b0) begin miscompares++; $display("FAIL len0_pulse: got %b want 0", reply_done); end
        repeat (8) begin
            @(negedge base_clk);
            if (div_en) saw_en = 1'b1;
        end
        vectors++; if (saw_en !== 1'b0) begin miscompares++; $display("FAIL len0_div_en: got %b want 0", saw_en); end
    endtask

    initial begin
        test_reset();
        test_reply_no_cfg();
        test_cfg_basic();
        test_cfg_err();
        test_cfg_random();
        test_reply_normal();
        test_reply_abort();
        test_abort_last_edge();
        test_cfg_during_run();
        test_rst_mid_run();
        test_reply_len0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
